// File: rtl/if_id_pipeline_controller.sv
// IF/ID pipeline flow controller.
// Decodes load-use and branch-operand hazards, branch/jump redirects and
// instruction-memory waits into the IF/ID hold/flush controls, the PC write
// enable and an ID/EX bubble. Also keeps saturating stall/flush statistics
// and a sticky watchdog flag for over-long stalls.
module if_id_pipeline_controller #(
  parameter logic [5:0] NOP_OPCODE = 6'b111000,
  parameter logic [5:0] BEQ_OPCODE = 6'b000100,
  parameter logic [5:0] BNE_OPCODE = 6'b000101,
  parameter logic [5:0] J_OPCODE   = 6'b000010,
  parameter logic [5:0] JAL_OPCODE = 6'b000011,
  parameter logic [5:0] SW_OPCODE  = 6'b101011,
  parameter int         MAX_STALL  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  ID_opcode,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        EX_MemRead,
  input  logic        EX_RegWrite,
  input  logic [4:0]  EX_dest,
  input  logic        MEM_MemRead,
  input  logic [4:0]  MEM_dest,
  input  logic        branch_taken,
  input  logic        imem_ready,
  output logic        PC_write,
  output logic        IF_ID_enable,
  output logic        IF_ID_flush,
  output logic        ID_EX_bubble,
  output logic        imem_abort,
  output logic        hazard_error,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  localparam int RUN_W = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_STALL);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_STALL - 1);

  typedef enum logic [1:0] {
    PRIME     = 2'd0,
    RUN       = 2'd1,
    IMEM_WAIT = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [RUN_W-1:0] run_len;

  logic is_nop;
  logic uses_rt;
  logic is_br;
  logic is_j;
  logic ex_hits_rs;
  logic ex_hits_rt;
  logic mem_hits_any;
  logic load_use;
  logic br_dep;
  logic stall;
  logic redirect;
  logic stall_cycle;
  logic flush_cycle;

  // Hazard decode; register 0 is hardwired so it never creates a dependency,
  // and a NOP sitting in ID never raises a hazard or redirect.
  always_comb begin
    is_nop       = (ID_opcode == NOP_OPCODE);
    uses_rt      = (ID_opcode == 6'b000000) || (ID_opcode == BEQ_OPCODE) ||
                   (ID_opcode == BNE_OPCODE) || (ID_opcode == SW_OPCODE);
    is_br        = (ID_opcode == BEQ_OPCODE) || (ID_opcode == BNE_OPCODE);
    is_j         = (ID_opcode == J_OPCODE) || (ID_opcode == JAL_OPCODE);
    ex_hits_rs   = (EX_dest != 5'd0) && (EX_dest == ID_rs);
    ex_hits_rt   = (EX_dest != 5'd0) && (EX_dest == ID_rt);
    mem_hits_any = (MEM_dest != 5'd0) && ((MEM_dest == ID_rs) || (MEM_dest == ID_rt));
    load_use     = ~is_nop & EX_MemRead & (ex_hits_rs | (uses_rt & ex_hits_rt));
    br_dep       = ~is_nop & is_br &
                   ((EX_RegWrite & (ex_hits_rs | ex_hits_rt)) | (MEM_MemRead & mem_hits_any));
    stall        = load_use | br_dep;
    redirect     = ~is_nop & ~stall & (is_j | (is_br & branch_taken));
  end

  // State register; reset parks the controller in PRIME so IF/ID starts as a NOP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= PRIME;
    end else begin
      state <= next_state;
    end
  end

  // Flow decode: stall beats redirect beats an instruction-memory wait.
  always_comb begin
    next_state   = state;
    PC_write     = 1'b0;
    IF_ID_enable = 1'b0;
    IF_ID_flush  = 1'b1;
    ID_EX_bubble = 1'b1;
    imem_abort   = 1'b0;
    case (state)
      PRIME: begin
        next_state = RUN;
      end
      RUN, IMEM_WAIT: begin
        if (stall) begin
          IF_ID_enable = 1'b1;
          IF_ID_flush  = 1'b0;
          ID_EX_bubble = 1'b1;
        end else if (redirect) begin
          PC_write     = 1'b1;
          IF_ID_flush  = 1'b1;
          ID_EX_bubble = 1'b0;
          imem_abort   = (state == IMEM_WAIT);
          next_state   = RUN;
        end else if (!imem_ready) begin
          IF_ID_flush  = 1'b1;
          ID_EX_bubble = 1'b0;
          next_state   = IMEM_WAIT;
        end else begin
          PC_write     = 1'b1;
          IF_ID_flush  = 1'b0;
          ID_EX_bubble = 1'b0;
          next_state   = RUN;
        end
      end
      default: begin
        next_state = PRIME;
      end
    endcase
  end

  // PRIME cycles are start-up noise and are kept out of the statistics.
  always_comb begin
    stall_cycle = (state != PRIME) & stall;
    flush_cycle = (state != PRIME) & IF_ID_flush & ~IF_ID_enable;
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      if (stall_cycle && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
      if (flush_cycle && (flush_count != 16'hFFFF)) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end

  // Stall watchdog: run length of consecutive stalls, sticky error once it hits the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_len      <= '0;
      hazard_error <= 1'b0;
    end else if (stall_cycle) begin
      if (run_len != RUN_MAX) begin
        run_len <= run_len + 1'b1;
      end
      if (run_len >= RUN_LAST) begin
        hazard_error <= 1'b1;
      end
    end else begin
      run_len <= '0;
    end
  end

endmodule

// File: tb/tb_if_id_pipeline_controller.sv
// Self-checking bench for if_id_pipeline_controller: directed scenarios plus
// randomized traffic, all compared against a cycle-level reference model.
module tb_if_id_pipeline_controller;

  logic        clk;
  logic        reset;
  logic [5:0]  ID_opcode;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic        EX_MemRead;
  logic        EX_RegWrite;
  logic [4:0]  EX_dest;
  logic        MEM_MemRead;
  logic [4:0]  MEM_dest;
  logic        branch_taken;
  logic        imem_ready;
  logic        PC_write;
  logic        IF_ID_enable;
  logic        IF_ID_flush;
  logic        ID_EX_bubble;
  logic        imem_abort;
  logic        hazard_error;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  int compared = 0;
  int failed   = 0;

  localparam int M_PRIME = 0;
  localparam int M_RUN   = 1;
  localparam int M_WAIT  = 2;

  int m_mode  = M_PRIME;
  int m_stall = 0;
  int m_flush = 0;
  int m_run   = 0;
  bit m_err   = 1'b0;

  logic [4:0] flow;
  assign flow = {PC_write, IF_ID_enable, IF_ID_flush, ID_EX_bubble, imem_abort};

  if_id_pipeline_controller dut (
    .clk(clk), .reset(reset), .ID_opcode(ID_opcode), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_dest(EX_dest),
    .MEM_MemRead(MEM_MemRead), .MEM_dest(MEM_dest), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .PC_write(PC_write), .IF_ID_enable(IF_ID_enable),
    .IF_ID_flush(IF_ID_flush), .ID_EX_bubble(ID_EX_bubble), .imem_abort(imem_abort),
    .hazard_error(hazard_error), .stall_count(stall_count), .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference hazard rules, expressed directly from the instruction semantics.
  function automatic bit ref_stall();
    bit is_nop, reads_rt, is_br, lu, bd;
    is_nop   = (ID_opcode == 6'b111000);
    reads_rt = (ID_opcode inside {6'd0, 6'b000100, 6'b000101, 6'b101011});
    is_br    = (ID_opcode inside {6'b000100, 6'b000101});
    if (is_nop) return 1'b0;
    lu = EX_MemRead && EX_dest != 0 && (EX_dest == ID_rs || (reads_rt && EX_dest == ID_rt));
    bd = is_br && ((EX_RegWrite && EX_dest != 0 && (EX_dest == ID_rs || EX_dest == ID_rt)) ||
                   (MEM_MemRead && MEM_dest != 0 && (MEM_dest == ID_rs || MEM_dest == ID_rt)));
    return lu || bd;
  endfunction

  function automatic bit ref_redirect();
    bit is_br;
    is_br = (ID_opcode inside {6'b000100, 6'b000101});
    if (ID_opcode == 6'b111000 || ref_stall()) return 1'b0;
    return (ID_opcode inside {6'b000010, 6'b000011}) || (is_br && branch_taken);
  endfunction

  // Expected {PC_write, enable, flush, bubble, abort} for the present cycle.
  function automatic logic [4:0] model_flow();
    if (m_mode == M_PRIME) return 5'b00110;
    if (ref_stall())       return 5'b01010;
    if (ref_redirect())    return {4'b1010, (m_mode == M_WAIT)};
    if (!imem_ready)       return 5'b00100;
    return 5'b10000;
  endfunction

  // Advance the model across one clock edge, then the real clock.
  task automatic advance();
    logic [4:0] f;
    bit s;
    f = model_flow();
    s = (m_mode != M_PRIME) && ref_stall();
    if (s) begin
      if (m_stall < 65535) m_stall++;
      if (m_run < 1000) m_run++;
      if (m_run >= 8) m_err = 1'b1;
    end else begin
      m_run = 0;
    end
    if (m_mode != M_PRIME && f[2] && !f[3] && m_flush < 65535) m_flush++;
    case (m_mode)
      M_PRIME: m_mode = M_RUN;
      M_RUN:   if (!s && !ref_redirect() && !imem_ready) m_mode = M_WAIT;
      default: if (!s && (ref_redirect() || imem_ready)) m_mode = M_RUN;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_mode = M_PRIME; m_stall = 0; m_flush = 0; m_run = 0; m_err = 1'b0;
  endtask

  task automatic idle_inputs();
    ID_opcode = 6'b111000; ID_rs = 0; ID_rt = 0;
    EX_MemRead = 0; EX_RegWrite = 0; EX_dest = 0;
    MEM_MemRead = 0; MEM_dest = 0; branch_taken = 0; imem_ready = 1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    model_reset();
    #3;
    compared++;
    if (flow !== 5'b00110) begin failed++; $display("FAIL reset_flow got %b want %b", flow, 5'b00110); end
    compared++;
    if (stall_count !== 16'd0 || flush_count !== 16'd0 || hazard_error !== 1'b0) begin
      failed++; $display("FAIL reset_regs got %h/%h/%b want 0/0/0", stall_count, flush_count, hazard_error);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if (flow !== model_flow()) begin failed++; $display("FAIL prime_flow got %b want %b", flow, model_flow()); end
    advance();
    @(negedge clk);
    compared++;
    if (flow !== model_flow()) begin failed++; $display("FAIL run_after_prime got %b want %b", flow, model_flow()); end
    advance();
  endtask

  task automatic test_load_use();
    ID_opcode = 6'd0; ID_rs = 5; ID_rt = 7; EX_MemRead = 1; EX_dest = 5;
    @(negedge clk);
    compared++;
    if (flow !== model_flow()) begin failed++; $display("FAIL load_use_stall got %b want %b", flow, model_flow()); end
    advance();
    EX_MemRead = 0; EX_dest = 0;
    @(negedge clk);
    compared++;
    if (flow !== model_flow()) begin failed++; $display("FAIL load_use_resume got %b want %b", flow, model_flow()); end
    compared++;
    if (stall_count !== 16'(m_stall)) begin failed++; $display("FAIL load_use_count got %0d want %0d", stall_count, m_stall); end
    advance();
    idle_inputs();
  endtask

  task automatic test_branch_dep();
    ID_opcode = 6'b000100; ID_rs = 3; ID_rt = 9; EX_RegWrite = 1; EX_dest = 3;
    @(negedge clk);
    compared++;
    if (flow !== model_flow()) begin failed++; $display("FAIL br_ex_dep got %b want %b", flow, model_flow()); end
    advance();
    EX_RegWrite = 0; EX_dest = 0; MEM_MemRead = 1; MEM_dest = 3; branch_taken = 1;
    @(negedge clk);
    compared++;
    if (flow !== model_flow()) begin failed++; $display("FAIL br_mem_dep got %b want %b", flow, model_flow()); end
    advance();
    MEM_MemRead = 0; MEM_dest = 0;
    @(negedge clk);
    compared++;
    if (flow !== model_flow()) begin failed++; $display("FAIL br_taken got %b want %b", flow, model_flow()); end
    advance();
    idle_inputs();
    @(negedge clk);
    compared++;
    if (flush_count !== 16'(m_flush) || stall_count !== 16'(m_stall)) begin
      failed++; $display("FAIL br_counts got %0d/%0d want %0d/%0d", flush_count, stall_count, m_flush, m_stall);
    end
    advance();
  endtask

  task automatic test_imem_wait();
    imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if (flow !== model_flow()) begin failed++; $display("FAIL imem_wait_%0d got %b want %b", i, flow, model_flow()); end
      advance();
    end
    ID_opcode = 6'b000010;
    @(negedge clk);
    compared++;
    if (flow !== model_flow()) begin failed++; $display("FAIL imem_abort got %b want %b", flow, model_flow()); end
    advance();
    idle_inputs();
    @(negedge clk);
    compared++;
    if (flow !== model_flow()) begin failed++; $display("FAIL imem_back_to_run got %b want %b", flow, model_flow()); end
    compared++;
    if (flush_count !== 16'(m_flush)) begin failed++; $display("FAIL imem_flush_count got %0d want %0d", flush_count, m_flush); end
    advance();
  endtask

  task automatic test_reset_mid_wait();
    imem_ready = 0;
    @(negedge clk);
    advance();
    reset = 1'b0;
    model_reset();
    #1;
    compared++;
    if (flow !== 5'b00110) begin failed++; $display("FAIL async_reset_flow got %b want %b", flow, 5'b00110); end
    compared++;
    if (stall_count !== 16'd0 || flush_count !== 16'd0 || hazard_error !== 1'b0) begin
      failed++; $display("FAIL async_reset_regs got %h/%h/%b want 0/0/0", stall_count, flush_count, hazard_error);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    idle_inputs();
  endtask

  task automatic test_random();
    logic [5:0] ops [9];
    ops = '{6'd0, 6'b000100, 6'b000101, 6'b000010, 6'b000011, 6'b101011, 6'b100011, 6'b001000, 6'b111000};
    for (int i = 0; i < 400; i++) begin
      ID_opcode    = ops[$urandom_range(0, 8)];
      ID_rs        = 5'($urandom_range(0, 3));
      ID_rt        = 5'($urandom_range(0, 3));
      EX_MemRead   = ($urandom_range(0, 3) == 0);
      EX_RegWrite  = ($urandom_range(0, 2) == 0);
      EX_dest      = 5'($urandom_range(0, 3));
      MEM_MemRead  = ($urandom_range(0, 3) == 0);
      MEM_dest     = 5'($urandom_range(0, 3));
      branch_taken = 1'($urandom_range(0, 1));
      imem_ready   = ($urandom_range(0, 4) != 0);
      @(negedge clk);
      compared++;
      if (flow !== model_flow()) begin failed++; $display("FAIL rand_flow_%0d got %b want %b", i, flow, model_flow()); end
      compared++;
      if (stall_count !== 16'(m_stall) || flush_count !== 16'(m_flush) || hazard_error !== m_err) begin
        failed++;
        $display("FAIL rand_regs_%0d got %0d/%0d/%b want %0d/%0d/%b", i, stall_count, flush_count, hazard_error, m_stall, m_flush, m_err);
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_watchdog_saturation();
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    ID_opcode = 6'd0; ID_rs = 5; ID_rt = 2; EX_MemRead = 1; EX_dest = 5;
    advance();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      compared++;
      if (hazard_error !== m_err) begin failed++; $display("FAIL watchdog_%0d got %b want %b", i, hazard_error, m_err); end
      advance();
    end
    for (int i = 0; i < 65540; i++) advance();
    @(negedge clk);
    compared++;
    if (stall_count !== 16'hFFFF || stall_count !== 16'(m_stall)) begin
      failed++; $display("FAIL stall_saturate got %h want %h", stall_count, 16'(m_stall));
    end
    compared++;
    if (hazard_error !== 1'b1) begin failed++; $display("FAIL watchdog_sticky got %b want 1", hazard_error); end
    idle_inputs();
    advance();
    @(negedge clk);
    compared++;
    if (hazard_error !== 1'b1 || stall_count !== 16'hFFFF) begin
      failed++; $display("FAIL sticky_after_clear got %b/%h want 1/ffff", hazard_error, stall_count);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_dep();
    test_imem_wait();
    test_reset_mid_wait();
    test_reset();
    test_random();
    test_watchdog_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
